unpool_stream: RTL and testbench
================================

Name: unpool_stream

Overview:
- Parametrised streaming successor to the fixed 2x2 unpooling stage in the CNN decoder path.
- Accepts a SIZE x SIZE pooled feature map, with one per-element window index from the matching max-pool stage, over a valid/ready stream.
- Emits the (SIZE*K) x (SIZE*K) unpooled map in raster order with backpressure.
- Buffers one pooled row at a time, not the whole map, and supports max-unpool and nearest-neighbour modes.

Parameters:
- DATA_W, 16: signed element width.
- SIZE, 8: pooled map side length, >=1.
- K, 2: pooling window side, >=2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a map when idle.
- mode  in  1  0 = max-unpool (index-placed, zeros elsewhere), 1 = nearest (replicate to whole window); latched at start.
- in_valid  in  1  pooled element valid.
- in_ready  out  1  block accepts element.
- in_data  in  DATA_W  pooled value.
- in_idx  in  IDX_W  window position, row-major: idx = dr*K + dc.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts element.
- out_data  out  DATA_W  unpooled value.
- out_last  out  1  high with the final element of the map.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, all counters 0, state=IDLE. Reset mid-map aborts and discards all buffered data.
- State IDLE:
  - start -> LOAD; latch mode; busy=1; row counter pr=0.
  - start while busy is ignored.
- State LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes row buffer entry [pc] with (in_data, in_idx); pc increments.
  - On pc==SIZE-1 handshake -> EMIT with or=0, oc=0.
- State EMIT:
  - in_ready=0.
  - Output register advances when !out_valid || out_ready.
  - Element (or, oc) uses pooled column pc=oc/K, window position dr=or, dc=oc%K.
  - mode 0: out_data = buf[pc].val if buf[pc].idx == dr*K+dc, else 0.
  - mode 1: out_data = buf[pc].val.
  - Raster order: oc = 0..SIZE*K-1, then or = 0..K-1.
  - After the final element of the band (or==K-1, oc==SIZE*K-1) is loaded into the output register:
    - if pr<SIZE-1: pr++ and -> LOAD.
    - else: -> DRAIN.
  - The next row is not accepted until the current band is fully loaded into the output register.
- State DRAIN:
  - Wait for the final out handshake.
  - Then out_valid=0, done=1 for one cycle, busy=0 -> IDLE.
- Latency: the first output element is registered one cycle after the last LOAD handshake of its row.
- out_data/out_valid/out_last hold stable while out_valid && !out_ready.
- out_last=1 only for element (SIZE*K-1, SIZE*K-1).
- Out-of-range index (in_idx >= K*K) in mode 0: the whole window outputs 0. No error flag.
- Per map: exactly SIZE*SIZE input handshakes and (SIZE*K)^2 output handshakes.
- in_valid outside LOAD has no effect.
- Counter widths are derived with the shared bits-required function. No arithmetic overflow is possible; values pass through unmodified.

Decomposition:
- Shared package/include holds:
  - IDX_W = bits_required(K*K-1), min 1.
  - Counter widths ROW_W = bits_required(SIZE), OUT_W = bits_required(SIZE*K).
  - State encoding IDLE/LOAD/EMIT/DRAIN.
  - MODE_MAX=0, MODE_NEAREST=1.
- Sub-module unpool_row_buf: SIZE-entry register array of {idx, val}, one write port, one combinational read port addressed by pc.

Test Plan:
- SIZE=2, K=2, mode 0, out_ready=1:
  - Stimulus: (5,0),(7,3),(-2,1),(9,2).
  - Required output: 5,0,0,0 / 0,0,0,7 / 0,-2,0,0 / 0,0,9,0.
  - out_last on the 16th element; done pulse one cycle after it.
- Same inputs, mode 1: outputs 5,5,7,7 / 5,5,7,7 / -2,-2,9,9 / -2,-2,9,9.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly. Output sequence is identical to the first test, with no drops or duplicates, and data stays stable while stalled. in_ready stays 0 throughout EMIT.
- Index 3 with K=2 is legal; idx=4 with K=3, SIZE=1, value 11 gives 0,0,0 / 0,11,0 / 0,0,0.
  - Out of range, SIZE=1, K=2: idx=7 (IDX_W=3, since IDX_W = bits_required(3)) gives an all-zero 2x2 window.
- Assert reset during the EMIT of row 0: all outputs return to reset values within the same cycle. A new start then produces the correct full map.
- start pulsed while busy: ignored, no extra done. Back-to-back maps: second start the cycle after done, and both maps are correct.

Source files
------------

// File: rtl/unpool_stream_pkg.sv
// Shared definitions for the streaming unpooling block.
//   - bits_required(): width helper used for every counter and the index port.
//   - state_e: control FSM encoding (IDLE/LOAD/EMIT/DRAIN).
//   - MODE_MAX / MODE_NEAREST: values of the latched mode bit.
package unpool_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic MODE_MAX     = 1'b0;
    localparam logic MODE_NEAREST = 1'b1;

    // Width that always holds 'value' itself, with at least one bit. For
    // non-powers of two this leaves headroom, so out-of-range window indices
    // (e.g. 7 when K=2) can still be presented on the index port.
    function automatic int bits_required(input int value);
        return (value < 1) ? 1 : $clog2(value) + 1;
    endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// One pooled row of {window index, value} pairs.
// Ports:
//   clk              - rising-edge clock
//   wr_en/wr_addr    - write strobe and column address
//   wr_idx/wr_val    - window index and pooled value to store
//   rd_addr          - combinational read column
//   rd_idx/rd_val    - stored index and value at rd_addr
// Contents carry no reset: every entry is rewritten before it is read.
module unpool_row_buf #(
    parameter int DATA_W = 16,
    parameter int SIZE   = 8,
    parameter int IDX_W  = 2,
    parameter int ROW_W  = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ROW_W-1:0]         wr_addr,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_val,
    input  logic [ROW_W-1:0]         rd_addr,
    output logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] rd_val
);

    logic [IDX_W-1:0]         idx_q [SIZE];
    logic [IDX_W-1:0]         idx_d [SIZE];
    logic signed [DATA_W-1:0] val_q [SIZE];
    logic signed [DATA_W-1:0] val_d [SIZE];

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            idx_d[i] = idx_q[i];
            val_d[i] = val_q[i];
            if (wr_en && (wr_addr == ROW_W'(i))) begin
                idx_d[i] = wr_idx;
                val_d[i] = wr_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            idx_q[i] <= idx_d[i];
            val_q[i] <= val_d[i];
        end
    end

    // Decoded read mux; avoids indexing the array with a wider-than-needed address.
    always_comb begin
        rd_idx = '0;
        rd_val = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (rd_addr == ROW_W'(i)) begin
                rd_idx = idx_q[i];
                rd_val = val_q[i];
            end
        end
    end

endmodule

// File: rtl/unpool_stream.sv
// Streaming SIZE x SIZE -> (SIZE*K) x (SIZE*K) unpooling stage.
// One pooled row is buffered, then expanded into a band of K output rows
// emitted in raster order; the next pooled row is accepted once the band
// has been fully loaded into the output register.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start, mode          - begin a map when idle; mode 0 = max-unpool, 1 = nearest
//   in_valid/in_ready    - pooled element handshake (in_data, in_idx = dr*K+dc)
//   out_valid/out_ready  - unpooled element handshake (out_data, out_last)
//   busy, done           - map in progress; one-cycle pulse after final output
module unpool_stream
    import unpool_stream_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  SIZE   = 8,
    parameter int  K      = 2,
    localparam int IDX_W  = bits_required(K * K - 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]         in_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W = bits_required(SIZE);
    localparam int OUT_W = bits_required(SIZE * K);

    localparam logic [ROW_W-1:0] LAST_PC = ROW_W'(SIZE - 1);
    localparam logic [OUT_W-1:0] LAST_OC = OUT_W'(SIZE * K - 1);
    localparam logic [OUT_W-1:0] LAST_KK = OUT_W'(K - 1);

    state_e                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [ROW_W-1:0]         pr_q, pr_d;       // pooled row being processed
    logic [ROW_W-1:0]         pc_q, pc_d;       // load column
    logic [ROW_W-1:0]         rd_pc_q, rd_pc_d; // emit column in pooled space (oc / K)
    logic [OUT_W-1:0]         dc_q, dc_d;       // oc % K
    logic [OUT_W-1:0]         oc_q, oc_d;       // output column
    logic [OUT_W-1:0]         or_q, or_d;       // row within the band (dr)
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     wr_en;
    logic [IDX_W-1:0]         rd_idx;
    logic signed [DATA_W-1:0] rd_val;
    logic [IDX_W-1:0]         tgt_idx;
    logic signed [DATA_W-1:0] pix;
    logic                     advance;
    logic                     band_end;

    unpool_row_buf #(
        .DATA_W (DATA_W),
        .SIZE   (SIZE),
        .IDX_W  (IDX_W),
        .ROW_W  (ROW_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (pc_q),
        .wr_idx  (in_idx),
        .wr_val  (in_data),
        .rd_addr (rd_pc_q),
        .rd_idx  (rd_idx),
        .rd_val  (rd_val)
    );

    // Element currently addressed by the emit counters. An out-of-range stored
    // index never equals a legal target, so its whole window reads as zero.
    always_comb begin
        tgt_idx = IDX_W'(int'(or_q) * K + int'(dc_q));
        if (mode_q == MODE_NEAREST) begin
            pix = rd_val;
        end else if (rd_idx == tgt_idx) begin
            pix = rd_val;
        end else begin
            pix = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pr_d        = pr_q;
        pc_d        = pc_q;
        rd_pc_d     = rd_pc_q;
        dc_d        = dc_q;
        oc_d        = oc_q;
        or_d        = or_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        advance     = !out_valid_q || out_ready;
        band_end    = (or_q == LAST_KK) && (oc_q == LAST_OC);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    pr_d    = '0;
                    pc_d    = '0;
                end
            end

            ST_LOAD: begin
                // The previous band's final element may still be waiting.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (in_valid && in_ready_q) begin
                    wr_en = 1'b1;
                    if (pc_q == LAST_PC) begin
                        pc_d    = '0;
                        state_d = ST_EMIT;
                        rd_pc_d = '0;
                        dc_d    = '0;
                        oc_d    = '0;
                        or_d    = '0;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end

            ST_EMIT: begin
                if (advance) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pix;
                    out_last_d  = (pr_q == LAST_PC) && band_end;
                    if (band_end) begin
                        if (pr_q != LAST_PC) begin
                            pr_d    = pr_q + 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (oc_q == LAST_OC) begin
                        oc_d    = '0;
                        rd_pc_d = '0;
                        dc_d    = '0;
                        or_d    = or_q + 1'b1;
                    end else begin
                        oc_d = oc_q + 1'b1;
                        if (dc_q == LAST_KK) begin
                            dc_d    = '0;
                            rd_pc_d = rd_pc_q + 1'b1;
                        end else begin
                            dc_d = dc_q + 1'b1;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_MAX;
            pr_q        <= '0;
            pc_q        <= '0;
            rd_pc_q     <= '0;
            dc_q        <= '0;
            oc_q        <= '0;
            or_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pr_q        <= pr_d;
            pc_q        <= pc_d;
            rd_pc_q     <= rd_pc_d;
            dc_q        <= dc_d;
            oc_q        <= oc_d;
            or_q        <= or_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_unpool_stream.sv
// Bench for unpool_stream: a SIZE=2,K=2 instance and a SIZE=1,K=3 instance
// share stimulus signals; sel picks which one a map targets.
module tb_unpool_stream;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 start0, start1, mode, in_valid, out_ready, sel;
    logic signed [DW-1:0] in_data;
    logic [3:0]           in_idx;

    logic in_ready0, out_valid0, out_last0, busy0, done0;
    logic in_ready1, out_valid1, out_last1, busy1, done1;
    logic signed [DW-1:0] out_data0, out_data1;

    logic in_ready, out_valid, out_last, busy, done;
    logic signed [DW-1:0] out_data;

    always_comb begin
        if (sel) begin
            in_ready  = in_ready1;
            out_valid = out_valid1;
            out_last  = out_last1;
            busy      = busy1;
            done      = done1;
            out_data  = out_data1;
        end else begin
            in_ready  = in_ready0;
            out_valid = out_valid0;
            out_last  = out_last0;
            busy      = busy0;
            done      = done0;
            out_data  = out_data0;
        end
    end

    unpool_stream #(.DATA_W(DW), .SIZE(2), .K(2)) u0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode),
        .in_valid(in_valid && !sel), .in_ready(in_ready0),
        .in_data(in_data), .in_idx(in_idx[2:0]),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0),
        .busy(busy0), .done(done0)
    );

    unpool_stream #(.DATA_W(DW), .SIZE(1), .K(3)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode),
        .in_valid(in_valid && sel), .in_ready(in_ready1),
        .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1),
        .busy(busy1), .done(done1)
    );

    typedef struct {
        logic              sel;
        logic              mode;
        logic              stall;
        int                n_in;
        int                n_out;
        int                rows;
        logic [0:3][15:0]  din;
        logic [0:3][3:0]   idx;
        logic [0:15][15:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready0,  0);
        chk({tag, "_out_valid"}, out_valid0, 0);
        chk({tag, "_out_data"},  out_data0,  0);
        chk({tag, "_out_last"},  out_last0,  0);
        chk({tag, "_busy"},      busy0,      0);
        chk({tag, "_done"},      done0,      0);
    endtask

    // Runs one map from table entry vi. abort_at>0 asserts reset after that many
    // output handshakes; restart_at>=0 pulses start again while busy.
    task automatic run_map(input int vi, input int abort_at, input int restart_at);
        vec_t v;
        int   ni, no, last_hs, band;
        bit   got_done, stalled, in_hs;
        logic signed [DW-1:0] held;
        v = tbl[vi];
        ni = 0; no = 0; last_hs = -10; got_done = 0; stalled = 0; held = '0;
        band = v.n_out / v.rows;
        @(posedge clk); #1;
        sel = v.sel;
        mode = v.mode;
        if (v.sel) start1 = 1'b1; else start0 = 1'b1;
        in_valid  = 1'b1;
        in_data   = $signed(v.din[0]);
        in_idx    = v.idx[0];
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk($sformatf("m%0d_busy", vi), busy, 1);
            if (stalled) begin
                chk($sformatf("m%0d_stall_valid", vi), out_valid, 1);
                chk($sformatf("m%0d_stall_data", vi), out_data, held);
            end
            if (in_ready && ni > 0 && (ni % v.rows) == 0)
                chk($sformatf("m%0d_in_ready_early", vi), (no + 1 >= band * (ni / v.rows)), 1);
            if (out_valid && out_ready) begin
                if (no < v.n_out)
                    chk($sformatf("m%0d_data%0d", vi, no), out_data, $signed(v.exp[no]));
                else
                    chk($sformatf("m%0d_extra_out", vi), no, v.n_out - 1);
                chk($sformatf("m%0d_last%0d", vi, no), out_last, (no == v.n_out - 1));
                no++;
                last_hs = cyc;
                if (abort_at > 0 && no == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk_reset_outputs("abort");
                    @(posedge clk); #1;
                    reset = 1'b0;
                    start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
                    return;
                end
            end
            if (done) begin
                got_done = 1;
                chk($sformatf("m%0d_done_timing", vi), cyc, last_hs + 1);
                chk($sformatf("m%0d_out_count", vi), no, v.n_out);
                chk($sformatf("m%0d_in_count", vi), ni, v.n_in);
            end
            in_hs   = in_valid && in_ready;
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(posedge clk); #1;
            start0 = 1'b0;
            start1 = 1'b0;
            if (restart_at == cyc) begin
                mode = !v.mode;
                if (v.sel) start1 = 1'b1; else start0 = 1'b1;
            end
            if (in_hs) begin
                ni++;
                if (ni < v.n_in) begin
                    in_data = $signed(v.din[ni]);
                    in_idx  = v.idx[ni];
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = v.stall ? stall_pat[(cyc + 1) % 4] : 1'b1;
        end
        if (!got_done) chk($sformatf("m%0d_timeout", vi), 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // sel, mode, stall, n_in, n_out, rows, din, idx, exp
        tbl[0] = '{1'b0, 1'b0, 1'b0, 4, 16, 2,
                   {16'd5, 16'd7, -16'sd2, 16'd9}, {4'd0, 4'd3, 4'd1, 4'd2},
                   {16'd5, 16'd0, 16'd0, 16'd0,  16'd0, 16'd0, 16'd0, 16'd7,
                    16'd0, -16'sd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd0}};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4, 16, 2,
                   {16'd5, 16'd7, -16'sd2, 16'd9}, {4'd0, 4'd3, 4'd1, 4'd2},
                   {16'd5, 16'd5, 16'd7, 16'd7, 16'd5, 16'd5, 16'd7, 16'd7,
                    -16'sd2, -16'sd2, 16'd9, 16'd9, -16'sd2, -16'sd2, 16'd9, 16'd9}};
        tbl[2] = tbl[0];
        tbl[2].stall = 1'b1;
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4, 16, 2,
                   {16'd4, 16'd6, 16'd8, 16'd10}, {4'd4, 4'd5, 4'd6, 4'd7},
                   {256{1'b0}}};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 4, 16, 2,
                   {16'd1, 16'd2, 16'd3, 16'd4}, {4'd7, 4'd7, 4'd7, 4'd7},
                   {16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                    16'd3, 16'd3, 16'd4, 16'd4, 16'd3, 16'd3, 16'd4, 16'd4}};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1, 9, 1,
                   {16'd11, 48'd0}, {4'd4, 12'd0},
                   {16'd0, 16'd0, 16'd0, 16'd0, 16'd11, 16'd0, 16'd0, 16'd0,
                    16'd0, 112'd0}};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1, 9, 1,
                   {16'd11, 48'd0}, {4'd9, 12'd0}, {256{1'b0}}};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1, 9, 1,
                   {-16'sd3, 48'd0}, {4'd0, 12'd0},
                   {{9{-16'sd3}}, 112'd0}};

        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; mode = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_map(i, -1, -1);

        // Reset in the middle of row 0's band, then a clean map.
        run_map(0, 3, -1);
        chk_reset_outputs("after_abort");
        run_map(0, -1, -1);

        // start while busy is ignored; nothing follows the single done.
        run_map(1, -1, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_extra_done", done, 0);
            chk("no_extra_busy", busy, 0);
        end

        // Back-to-back maps.
        run_map(0, -1, -1);
        run_map(1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
